// File: rtl/gf_xmul_iter_pkg.sv
// Shared types and constants for the iterative GF(2^W) multiply engine.
// Contents: operation mode enum, FSM state enum, AES reduction polynomial,
// and the helper that derives the x^-1 reduction constant from POLY.
package gf_pkg;

    localparam int unsigned GF_MAX_W = 32;
    localparam logic [7:0]  GF_AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        GF_MUL  = 2'd0,
        GF_MULX = 2'd1,
        GF_DIVX = 2'd2,
        GF_PASS = 2'd3
    } gf_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gf_state_e;

    // Constant xored in after a right shift when the LSB was set:
    // (v ^ P(x)) >> 1 with P monic and P[0]=1 gives {1, POLY[W-1:1]}.
    function automatic logic [GF_MAX_W-1:0] gf_divc(input logic [GF_MAX_W-1:0] poly,
                                                    input int unsigned       w);
        return (poly >> 1) | (GF_MAX_W'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/gf_xmul_iter_if.sv
// Request/response bus of the GF(2^W) engine.
// Request : in_valid/in_ready handshake, in_mode, in_shift, in_a, in_b.
// Response: out_valid/out_ready handshake, out_c.
// Lane i of every data vector occupies bits [i*W +: W].
interface gf_xmul_iter_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned SHW   = 8
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_mode;
    logic [SHW-1:0]       in_shift;
    logic [LANES*W-1:0]   in_a;
    logic [LANES*W-1:0]   in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_c;

    modport master (
        output in_valid, in_mode, in_shift, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c
    );

    modport slave (
        input  in_valid, in_mode, in_shift, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c
    );

endinterface

// File: rtl/gf_xmul_iter_xstep.sv
// One reduction step of a single lane (purely combinational).
// i_v     : current accumulator
// i_b_bit : multiplier bit consumed this step (MUL only)
// i_a     : multiplicand (MUL only)
// i_op    : operation mode
// o_nxt_c : accumulator after this step
module gf_xstep
    import gf_pkg::*;
#(
    parameter int unsigned   W    = 8,
    parameter logic [W-1:0]  POLY = W'(GF_AES_POLY)
) (
    input  logic [W-1:0] i_v,
    input  logic         i_b_bit,
    input  logic [W-1:0] i_a,
    input  gf_mode_e     i_op,
    output logic [W-1:0] o_nxt_c
);

    localparam logic [W-1:0] DIVC = W'(gf_divc(GF_MAX_W'(POLY), W));

    logic [W-1:0] w_mulx;
    logic [W-1:0] w_divx;

    // Multiply / divide by x with reduction.
    always_comb begin
        w_mulx = {i_v[W-2:0], 1'b0} ^ (i_v[W-1] ? POLY : '0);
        w_divx = {1'b0, i_v[W-1:1]} ^ (i_v[0] ? DIVC : '0);
    end

    // Select step result for the operation.
    always_comb begin
        o_nxt_c = i_v;
        case (i_op)
            GF_MUL:  o_nxt_c = w_mulx ^ (i_b_bit ? i_a : '0);
            GF_MULX: o_nxt_c = w_mulx;
            GF_DIVX: o_nxt_c = w_divx;
            default: o_nxt_c = i_v;
        endcase
    end

endmodule

// File: rtl/gf_xmul_iter.sv
// Iterative multi-lane GF(2^W) engine: a*b, a*x^n, a*x^-n, pass-through.
// One reduction step per clock, all lanes in lockstep.
// clk   : clock
// rst_n : synchronous active-low reset
// bus   : request/response handshake bus (slave side)
module gf_xmul_iter
    import gf_pkg::*;
#(
    parameter int unsigned   W     = 8,
    parameter logic [W-1:0]  POLY  = W'(GF_AES_POLY),
    parameter int unsigned   LANES = 4,
    parameter int unsigned   SHW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    gf_xmul_iter_if.slave bus
);

    localparam int unsigned DW  = LANES * W;
    localparam int unsigned CLW = $clog2(W + 1);
    localparam int unsigned CW  = (SHW > CLW) ? SHW : CLW;

    gf_state_e        r_state;
    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_acc;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    gf_mode_e         r_mode;
    logic [DW-1:0]    r_out_c;
    logic             r_in_ready;
    logic             r_out_valid;

    gf_state_e        w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [DW-1:0]    w_acc_nxt;
    logic [DW-1:0]    w_a_nxt;
    logic [DW-1:0]    w_b_nxt;
    gf_mode_e         w_mode_nxt;
    logic [DW-1:0]    w_out_c_nxt;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;
    gf_mode_e         w_mode_in;
    logic [CW-1:0]    w_cnt_in;
    logic [DW-1:0]    w_step;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_c     = r_out_c;

    // Per-lane step; b is consumed MSB-first from the top bit of each lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        gf_xstep #(
            .W    (W),
            .POLY (POLY)
        ) u_xstep (
            .i_v     (r_acc[gi*W +: W]),
            .i_b_bit (r_b[gi*W + W - 1]),
            .i_a     (r_a[gi*W +: W]),
            .i_op    (r_mode),
            .o_nxt_c (w_step[gi*W +: W])
        );
    end

    // Step count for an incoming request.
    always_comb begin
        w_mode_in = gf_mode_e'(bus.in_mode);
        w_cnt_in  = '0;
        case (w_mode_in)
            GF_MUL:  w_cnt_in = CW'(W);
            GF_MULX: w_cnt_in = CW'(bus.in_shift);
            GF_DIVX: w_cnt_in = CW'(bus.in_shift);
            default: w_cnt_in = '0;
        endcase
    end

    // Next state and datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_mode_nxt  = r_mode;
        w_out_c_nxt = r_out_c;
        case (r_state)
            ST_IDLE: begin
                // r_in_ready gates accept so nothing slips in on the first edge after reset
                if (bus.in_valid && r_in_ready) begin
                    w_a_nxt    = bus.in_a;
                    w_b_nxt    = bus.in_b;
                    w_mode_nxt = w_mode_in;
                    w_cnt_nxt  = w_cnt_in;
                    if (w_cnt_in == '0) begin
                        w_state_nxt = ST_DONE;
                        w_acc_nxt   = bus.in_a;
                        w_out_c_nxt = bus.in_a;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_acc_nxt   = (w_mode_in == GF_MUL) ? '0 : bus.in_a;
                    end
                end
            end
            ST_RUN: begin
                w_acc_nxt = w_step;
                w_cnt_nxt = r_cnt - CW'(1);
                // whole-vector shift keeps each lane's next bit at its MSB for W steps
                w_b_nxt   = r_b << 1;
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_DONE;
                    w_out_c_nxt = w_step;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
        w_out_valid_nxt = (w_state_nxt == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= GF_PASS;
            r_out_c     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_mode      <= w_mode_nxt;
            r_out_c     <= w_out_c_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule
